// File: rtl/ov7620_capture_module.sv
// ============================================================================
// ov7620_capture_module
//
// Captures the luma stream of an OV7620 camera into the CLK domain.
// VSYNC, HREF, PCLK and the Y bus are oversampled by CLK through a
// two-flop synchronizer followed by a history flop. Edges are found by
// comparing the second synchronizer stage with the history stage. A
// three-state FSM (IDLE / FRAME / LINE) counts accepted pixels and
// completed lines.
//
// Timing: an input change first sampled at CLK edge N is seen by edge
// detection after edge N+1. The registered pulse is therefore high during
// the third cycle that starts at or after edge N, and lasts one cycle.
//
// Build option:
//   OV7620_CAPTURE_TEST_PATTERN_EN - when defined, Y_Data carries
//   Pixel_Count[7:0] ^ Line_Count[7:0] (values before increment) instead
//   of CAM_Y. Timing is identical in both builds.
//
// Parameters:
//   H_ACTIVE    pixels per line (default 640)
//   V_ACTIVE    lines per frame (default 240)
//
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   CAM_VSYNC   camera frame sync (asynchronous)
//   CAM_HREF    camera line valid (asynchronous)
//   CAM_PCLK    camera pixel clock, sampled as data (asynchronous)
//   CAM_Y       camera luma bus (asynchronous)
//   H2L_Sig_V   one-cycle pulse on VSYNC falling edge
//   L2H_Sig_V   one-cycle pulse on VSYNC rising edge
//   L2H_Sig_H   synchronized HREF level
//   L2H_Sig_P   one-cycle pulse per accepted pixel
//   Y_Data      luma of the last accepted pixel
//   Pixel_Count accepted pixels in the current line
//   Line_Count  completed lines in the current frame
//   Frame_Done  one-cycle pulse at the end of a frame
//   Overflow    sticky flag: too many pixels in a line or lines in a frame
// ============================================================================
module ov7620_capture_module #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 240
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CAM_VSYNC,
    input  logic       CAM_HREF,
    input  logic       CAM_PCLK,
    input  logic [7:0] CAM_Y,
    output logic       H2L_Sig_V,
    output logic       L2H_Sig_V,
    output logic       L2H_Sig_H,
    output logic       L2H_Sig_P,
    output logic [7:0] Y_Data,
    output logic [9:0] Pixel_Count,
    output logic [8:0] Line_Count,
    output logic       Frame_Done,
    output logic       Overflow
);

    typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;

    // Bit positions inside the packed control-signal synchronizer.
    localparam int CTRL_V = 2;
    localparam int CTRL_H = 1;
    localparam int CTRL_P = 0;

    localparam logic [9:0] H_MAX = 10'(H_ACTIVE);
    localparam logic [8:0] V_MAX = 9'(V_ACTIVE);

    // ------------------------------------------------------------------
    // Synchronizers: s1, s2 for metastability, s3 as edge history.
    // ------------------------------------------------------------------
    logic [2:0] ctrl_s1_reg, ctrl_s2_reg, ctrl_s3_reg;
    logic [7:0] y_s1_reg, y_s2_reg, y_s3_reg;
    logic [2:0] ctrl_rise, ctrl_fall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_s1_reg <= '0;
            ctrl_s2_reg <= '0;
            ctrl_s3_reg <= '0;
            y_s1_reg    <= '0;
            y_s2_reg    <= '0;
            y_s3_reg    <= '0;
        end else begin
            ctrl_s1_reg <= {CAM_VSYNC, CAM_HREF, CAM_PCLK};
            ctrl_s2_reg <= ctrl_s1_reg;
            ctrl_s3_reg <= ctrl_s2_reg;
            y_s1_reg    <= CAM_Y;
            y_s2_reg    <= y_s1_reg;
            y_s3_reg    <= y_s2_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            assign ctrl_rise[gi] =  ctrl_s2_reg[gi] & ~ctrl_s3_reg[gi];
            assign ctrl_fall[gi] = ~ctrl_s2_reg[gi] &  ctrl_s3_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Luma source. CAM_Y at s3 was sampled while PCLK was still low,
    // i.e. the data the camera presented for the rising PCLK edge.
    // ------------------------------------------------------------------
    logic [9:0] pixel_count_reg, pixel_count_next;
    logic [8:0] line_count_reg, line_count_next;
    logic [7:0] y_src;

`ifdef OV7620_CAPTURE_TEST_PATTERN_EN
    assign y_src = pixel_count_reg[7:0] ^ line_count_reg[7:0];
`else
    assign y_src = y_s3_reg;
`endif

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [7:0] y_data_reg, y_data_next;
    logic       overflow_reg, overflow_next;
    logic       pixel_pulse_reg, pixel_pulse_next;
    logic       frame_done_reg, frame_done_next;
    logic       h2l_v_reg, l2h_v_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= IDLE;
            pixel_count_reg <= '0;
            line_count_reg  <= '0;
            y_data_reg      <= '0;
            overflow_reg    <= 1'b0;
            pixel_pulse_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            h2l_v_reg       <= 1'b0;
            l2h_v_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pixel_count_reg <= pixel_count_next;
            line_count_reg  <= line_count_next;
            y_data_reg      <= y_data_next;
            overflow_reg    <= overflow_next;
            pixel_pulse_reg <= pixel_pulse_next;
            frame_done_reg  <= frame_done_next;
            // VSYNC pulses are reported in every state, IDLE included.
            h2l_v_reg       <= ctrl_fall[CTRL_V];
            l2h_v_reg       <= ctrl_rise[CTRL_V];
        end
    end

    always_comb begin
        state_next       = state_reg;
        pixel_count_next = pixel_count_reg;
        line_count_next  = line_count_reg;
        y_data_next      = y_data_reg;
        overflow_next    = overflow_reg;
        pixel_pulse_next = 1'b0;
        frame_done_next  = 1'b0;

        // VSYNC edges take priority: a coincident PCLK or HREF edge is dropped.
        if (ctrl_fall[CTRL_V]) begin
            state_next       = FRAME;
            pixel_count_next = '0;
            line_count_next  = '0;
            overflow_next    = 1'b0;
        end else if (ctrl_rise[CTRL_V]) begin
            // Line_Count is left untouched so it can be read after the frame.
            if (state_reg != IDLE) begin
                frame_done_next = 1'b1;
            end
            state_next = IDLE;
        end else begin
            case (state_reg)
                FRAME: begin
                    if (ctrl_rise[CTRL_H]) begin
                        pixel_count_next = '0;
                        state_next       = LINE;
                    end
                end
                LINE: begin
                    if (ctrl_fall[CTRL_H]) begin
                        // Empty lines (no accepted pixel) are not counted.
                        if (pixel_count_reg != '0) begin
                            if (line_count_reg == V_MAX) begin
                                overflow_next = 1'b1;
                            end else begin
                                line_count_next = line_count_reg + 9'd1;
                            end
                        end
                        state_next = FRAME;
                    end else if (ctrl_rise[CTRL_P]) begin
                        if (pixel_count_reg == H_MAX) begin
                            overflow_next = 1'b1;
                        end else begin
                            pixel_count_next = pixel_count_reg + 10'd1;
                            y_data_next      = y_src;
                            pixel_pulse_next = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign H2L_Sig_V   = h2l_v_reg;
    assign L2H_Sig_V   = l2h_v_reg;
    assign L2H_Sig_H   = ctrl_s3_reg[CTRL_H];
    assign L2H_Sig_P   = pixel_pulse_reg;
    assign Y_Data      = y_data_reg;
    assign Pixel_Count = pixel_count_reg;
    assign Line_Count  = line_count_reg;
    assign Frame_Done  = frame_done_reg;
    assign Overflow    = overflow_reg;

endmodule
